// File: rtl/prior_decoder.sv
// Buffered 3-to-8 decoder: queues {flag, code} entries and replays each one for HOLD_CYCLES cycles.
// Optional `PRIOR_DECODER_STALL_CNT_EN adds a saturating count of stalled input cycles.
module prior_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_code,
  input  logic       in_flag,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       en,
  output logic [7:0] led_out,
  output logic [7:0] seg_out,
  output logic       busy
`ifdef PRIOR_DECODER_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int HW   = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_nxt;
  logic [3:0]      cur;

  function automatic logic [7:0] glyph(input logic [2:0] c);
    case (c)
      3'd0:    glyph = 8'h03;
      3'd1:    glyph = 8'h9F;
      3'd2:    glyph = 8'h25;
      3'd3:    glyph = 8'h0D;
      3'd4:    glyph = 8'h99;
      3'd5:    glyph = 8'h49;
      3'd6:    glyph = 8'h41;
      default: glyph = 8'h1F;
    endcase
  endfunction

  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;

  // Pops only ever read entries already stored; a push this cycle is not visible until next cycle.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          hold_nxt  = HW'(HOLD_CYCLES - 1);
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - HW'(1);
        end else if (!empty) begin
          pop      = 1'b1;
          hold_nxt = HW'(HOLD_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      cur      <= 4'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (pop) cur <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_flag, in_code};
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    led_out = 8'h00;
    seg_out = 8'hFF;
    if (en && cur[3]) begin
      led_out = 8'b1 << cur[2:0];
      seg_out = glyph(cur[2:0]);
    end
  end

  assign busy = (state == SHOW) || !empty;

`ifdef PRIOR_DECODER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 8'd0;
    end else if (in_valid && !in_ready && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prior_decoder.sv
// Self-checking bench for prior_decoder: schedule-based reference model plus directed literal checks.
// Also exercises the stall counter when `PRIOR_DECODER_STALL_CNT_EN is defined.
module tb_prior_decoder;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_code;
  logic       in_flag;
  logic       in_valid;
  logic       in_ready;
  logic       en;
  logic [7:0] led_out;
  logic [7:0] seg_out;
  logic       busy;
`ifdef PRIOR_DECODER_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  prior_decoder #(.HOLD_CYCLES(HOLD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_code  (in_code),
    .in_flag  (in_flag),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .en       (en),
    .led_out  (led_out),
    .seg_out  (seg_out),
    .busy     (busy)
`ifdef PRIOR_DECODER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_tab [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

  // Each accepted entry is described by the cycle it was accepted in and the cycle its display starts.
  typedef struct {
    int         acc;
    int         start;
    logic       flag;
    logic [2:0] code;
  } ent_t;

  ent_t sched[$];
  int   cyc       = 0;
  int   last_end  = -1000;
  int   exp_stall = 0;
  bit   model_on  = 1'b0;

  function automatic int fifo_count(input int t);
    int n = 0;
    foreach (sched[i]) if (sched[i].acc + 1 <= t && t <= sched[i].start - 1) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic f,
                               input logic [2:0] c, input logic e);
    rst_n    = r;
    in_valid = v;
    in_flag  = f;
    in_code  = c;
    en       = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepts entries and schedules display windows back to back.
  always @(posedge clk) begin
    if (!rst_n) begin
      sched.delete();
      last_end  = -1000;
      exp_stall = 0;
      model_on  = 1'b1;
    end else begin
      bit   rdy;
      ent_t e;
      rdy = fifo_count(cyc) < DEPTH;
      if (in_valid && rdy) begin
        e.acc   = cyc;
        e.start = (cyc + 2 > last_end) ? cyc + 2 : last_end;
        e.flag  = in_flag;
        e.code  = in_code;
        last_end = e.start + HOLD;
        sched.push_back(e);
      end else if (in_valid && !rdy && exp_stall < 255) begin
        exp_stall++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_on) begin
      int         n;
      logic       b;
      logic       f;
      logic [2:0] c;
      logic [7:0] el;
      logic [7:0] es;
      n = 0;
      b = 1'b0;
      f = 1'b0;
      c = 3'd0;
      foreach (sched[i]) begin
        if (sched[i].acc + 1 <= cyc && cyc <= sched[i].start - 1) n++;
        if (sched[i].acc + 1 <= cyc && cyc < sched[i].start + HOLD) b = 1'b1;
        if (sched[i].start <= cyc) begin
          f = sched[i].flag;
          c = sched[i].code;
        end
      end
      el = (en && f) ? (8'h01 << c) : 8'h00;
      es = (en && f) ? glyph_tab[c] : 8'hFF;
      checkOutput("model_in_ready", {7'b0, in_ready}, {7'b0, (rst_n && n < DEPTH)});
      checkOutput("model_busy", {7'b0, busy}, {7'b0, b});
      checkOutput("model_led", led_out, el);
      checkOutput("model_seg", seg_out, es);
`ifdef PRIOR_DECODER_STALL_CNT_EN
      checkOutput("model_stall", stall_cnt, 8'(exp_stall));
`endif
    end
  end

  task automatic runSequence(input string name, input logic [11:0] ents,
                             input logic [23:0] exp_led, input logic [23:0] exp_seg);
    for (int k = 0; k < 16; k++) begin
      if (k < 3) applyStimulus(1'b1, 1'b1, ents[4*k+3], ents[4*k +: 3], 1'b1);
      else       applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
      if (k >= 2 && k < 14) begin
        checkOutput({name, "_led"}, led_out, exp_led[8*((k-2)/4) +: 8]);
        checkOutput({name, "_seg"}, seg_out, exp_seg[8*((k-2)/4) +: 8]);
      end
      tick();
    end
    checkOutput({name, "_busy_end"}, {7'b0, busy}, 8'h00);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd5, 1'b1);

    // Reset held for three cycles with a valid offer pending.
    repeat (3) begin
      tick();
      checkOutput("rst_led", led_out, 8'h00);
      checkOutput("rst_seg", seg_out, 8'hFF);
      checkOutput("rst_ready", {7'b0, in_ready}, 8'h00);
      checkOutput("rst_busy", {7'b0, busy}, 8'h00);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (3) tick();
    checkOutput("post_rst_led", led_out, 8'h00);
    checkOutput("post_rst_busy", {7'b0, busy}, 8'h00);

    // Single entry, code 5.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("single_led", led_out, 8'h20);
    checkOutput("single_seg", seg_out, 8'h49);
    checkOutput("single_busy", {7'b0, busy}, 8'h01);
    repeat (4) tick();
    checkOutput("single_idle_busy", {7'b0, busy}, 8'h00);
    checkOutput("single_hold_led", led_out, 8'h20);
    checkOutput("single_hold_seg", seg_out, 8'h49);

    runSequence("b2b", {1'b1, 3'd7, 1'b1, 3'd0, 1'b1, 3'd3},
                {8'h80, 8'h01, 8'h08}, {8'h1F, 8'h03, 8'h0D});
    runSequence("blank", {1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 3'd2},
                {8'h40, 8'h00, 8'h04}, {8'h41, 8'hFF, 8'h25});

    // Overflow: ten consecutive offers into a four-deep FIFO.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 3'(k), 1'b1);
      if (k == 4) checkOutput("ovf_ready_k4", {7'b0, in_ready}, 8'h01);
      if (k == 5) checkOutput("ovf_ready_full", {7'b0, in_ready}, 8'h00);
      if (k == 6) checkOutput("ovf_ready_after_pop", {7'b0, in_ready}, 8'h01);
      if (k == 7) checkOutput("ovf_ready_full2", {7'b0, in_ready}, 8'h00);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
`ifdef PRIOR_DECODER_STALL_CNT_EN
    checkOutput("ovf_stall_cnt", stall_cnt, 8'd4);
`endif
    repeat (30) tick();
    checkOutput("ovf_drained_busy", {7'b0, busy}, 8'h00);
    checkOutput("ovf_last_led", led_out, 8'h40);

    // Display enable dropped mid-hold of code 4.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("en_led_on", led_out, 8'h10);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("en_off_led", led_out, 8'h00);
    checkOutput("en_off_seg", seg_out, 8'hFF);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    #1;
    checkOutput("en_back_led", led_out, 8'h10);
    checkOutput("en_back_seg", seg_out, 8'h99);
    repeat (2) tick();
    checkOutput("en_idle_busy", {7'b0, busy}, 8'h00);

    // Randomized traffic with occasional resets; the model process checks every cycle.
    for (int k = 0; k < 1500; k++) begin
      applyStimulus(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 3) != 0), 3'($urandom()),
                    ($urandom_range(0, 7) != 0));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
